// File: rtl/beep_decoder_if.sv
// Tone-input / note-output bundle for beep_decoder.
// slave is the decoder side; master is whoever drives the tone and watches the note.
interface beep_decoder_if;
  logic        beep_in;
  logic [2:0]  note_code;
  logic        note_valid;
  logic        note_strobe;
  logic [17:0] period_out;

  modport master (output beep_in, input note_code, note_valid, note_strobe, period_out);
  modport slave  (input beep_in, output note_code, note_valid, note_strobe, period_out);
endinterface

// File: rtl/beep_decoder.sv
// beep_decoder: measures the rising-edge period of beep_in and locks onto one of DO..XI.
// Optional macro BEEP_DEC_DUTY_EN also requires the low time to sit near half the note period.
module beep_decoder #(
  parameter logic [17:0] DO         = 18'd190839,
  parameter logic [17:0] RE         = 18'd170067,
  parameter logic [17:0] MI         = 18'd151514,
  parameter logic [17:0] FA         = 18'd143265,
  parameter logic [17:0] SO         = 18'd127550,
  parameter logic [17:0] LA         = 18'd113635,
  parameter logic [17:0] XI         = 18'd101213,
  parameter logic [17:0] TOL        = 18'd2000,
  parameter logic [2:0]  STABLE_CNT = 3'd3,
  parameter logic [19:0] TIMEOUT    = 20'd999_999
) (
  input logic           sys_clk,
  input logic           sys_rst,
  beep_decoder_if.slave bus
);
  localparam logic [2:0] NONE = 3'd7;
  localparam logic [6:0][17:0] NOTES = {XI, LA, SO, FA, MI, RE, DO};

  typedef enum logic [1:0] {IDLE, ARM, TRACK, LOCK} state_e;

  logic        s1_q, s2_q, dly_q, edge_q, rise;
  logic [17:0] pcnt_q, pcnt_d, period_q;
  logic [19:0] tcnt_q, tcnt_d;
  logic        tmo;
  logic [2:0]  cls, mnext;
  state_e      state_q;
  logic [2:0]  cand_q, mcnt_q, code_q;
  logic        valid_q, strobe_q;

  assign rise   = s2_q & ~dly_q;
  assign pcnt_d = rise ? '0 : (&pcnt_q) ? pcnt_q : pcnt_q + 18'd1;
  assign tcnt_d = rise ? '0 : (tcnt_q >= TIMEOUT) ? TIMEOUT : tcnt_q + 20'd1;
  // An edge landing on the threshold cycle cancels the timeout.
  assign tmo    = (tcnt_q == TIMEOUT) && !rise;

  function automatic logic near(input logic [17:0] v, input logic [17:0] tgt);
    logic signed [18:0] diff;
    diff = $signed({1'b0, v}) - $signed({1'b0, tgt});
    if (diff[18]) diff = -diff;
    return diff <= $signed({1'b0, TOL});
  endfunction

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      dly_q    <= 1'b0;
      edge_q   <= 1'b0;
      pcnt_q   <= '0;
      tcnt_q   <= '0;
      period_q <= '0;
    end else begin
      s1_q   <= bus.beep_in;
      s2_q   <= s1_q;
      dly_q  <= s2_q;
      edge_q <= rise;
      pcnt_q <= pcnt_d;
      tcnt_q <= tcnt_d;
      if (rise) period_q <= pcnt_q;
    end
  end

`ifdef BEEP_DEC_DUTY_EN
  logic        fall;
  logic [17:0] lcnt_q, lcnt_d, low_q;

  assign fall   = ~s2_q & dly_q;
  assign lcnt_d = fall ? '0 : (!s2_q && !(&lcnt_q)) ? lcnt_q + 18'd1 : lcnt_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      lcnt_q <= '0;
      low_q  <= '0;
    end else begin
      lcnt_q <= lcnt_d;
      if (rise) low_q <= lcnt_q;
    end
  end

  // Scan high-to-low so the earliest note in DO..XI order wins.
  always_comb begin
    cls = NONE;
    for (int k = 6; k >= 0; k--)
      if (near(period_q, NOTES[k]) && near(low_q, (NOTES[k] >> 1) + 18'd1)) cls = 3'(k);
  end
`else
  always_comb begin
    cls = NONE;
    for (int k = 6; k >= 0; k--)
      if (near(period_q, NOTES[k])) cls = 3'(k);
  end
`endif

  assign mnext = (cls == cand_q && cls != NONE) ? mcnt_q + 3'd1 : {2'b00, cls != NONE};

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= IDLE;
      cand_q   <= NONE;
      mcnt_q   <= '0;
      code_q   <= NONE;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (tmo && state_q != IDLE) begin
        state_q <= IDLE;
        cand_q  <= NONE;
        mcnt_q  <= '0;
        code_q  <= NONE;
        valid_q <= 1'b0;
      end else if (edge_q) begin
        case (state_q)
          IDLE: state_q <= ARM;
          ARM, TRACK: begin
            cand_q <= cls;
            mcnt_q <= mnext;
            if (mnext >= STABLE_CNT) begin
              state_q  <= LOCK;
              code_q   <= cls;
              valid_q  <= 1'b1;
              strobe_q <= !valid_q || (code_q != cls);
            end else begin
              state_q <= TRACK;
            end
          end
          LOCK: begin
            // Leave the old note visible while re-tracking across a glitch.
            if (cls != code_q) begin
              state_q <= TRACK;
              cand_q  <= cls;
              mcnt_q  <= {2'b00, cls != NONE};
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.note_code   = code_q;
  assign bus.note_valid  = valid_q;
  assign bus.note_strobe = strobe_q;
  assign bus.period_out  = period_q;
endmodule

// File: doc/beep_decoder.md
Name: beep_decoder

Overview:
- Receive-side counterpart of the team's tone generator. Measures the period of an incoming square wave (a buzzer drive line, or a looped-back tone output) and classifies it as one of the seven scale notes DO..XI.
- Asserts a stable note code once several consecutive periods agree.
- Reports silence after a timeout with no edges.
- Used for loopback self-test of the tone path and for note-driven control logic.

Parameters:
- DO, 18'd190839, note period in sys_clk cycles minus 1 (a captured value of DO means a period of DO+1 cycles)
- RE, 18'd170067, as above
- MI, 18'd151514, as above
- FA, 18'd143265, as above
- SO, 18'd127550, as above
- LA, 18'd113635, as above
- XI, 18'd101213, as above
- TOL, 18'd2000, allowed absolute deviation between captured value and note parameter
- STABLE_CNT, 3'd3, consecutive matching periods required to lock (1..7)
- TIMEOUT, 20'd999_999, cycles without a rising edge before silence is declared

Ports:
- sys_clk  input  1  system clock
- sys_rst  input  1  synchronous reset, active-high
- beep_in  input  1  asynchronous tone input
- note_code  output  3  0=DO 1=RE 2=MI 3=FA 4=SO 5=LA 6=XI 7=none
- note_valid  output  1  high while a note is locked
- note_strobe  output  1  one-cycle pulse when note_code changes to a new locked note
- period_out  output  18  last captured period value (cycles minus 1)

Behaviour:
- **Synchroniser and edge detect**
  - beep_in passes through a 2-flop synchroniser, then a 1-flop delay for edge detection.
  - edge = synced & ~delayed.
  - All synchroniser flops reset to 0.
- **Period counter (18 bit)**
  - Clears to 0 on an edge cycle; otherwise increments.
  - Saturates at 18'h3FFFF.
  - On an edge cycle the pre-clear value is captured into period_out. With the team's generator, the captured value equals the note parameter exactly.
- **Timeout counter (20 bit)**
  - Clears on an edge; otherwise increments, saturating at TIMEOUT.
  - Timeout fires on a cycle where the counter == TIMEOUT and there is no edge. If an edge and the threshold coincide, the edge wins.
- **Classification** (combinational, on the captured value)
  - Class k when |value - NOTE_k| <= TOL; otherwise class 7.
  - Compares the first match in DO..XI order. Subtraction is done in 19-bit signed arithmetic; there is no wrap.
- **FSM states:** IDLE, ARM, TRACK, LOCK.
  - IDLE: first edge -> ARM. No capture is used, because the first period is unreferenced.
  - ARM/TRACK, on each edge:
    - If class == cand and class != 7: match_cnt++.
    - Else: cand = class; match_cnt = (class != 7) ? 1 : 0.
    - ARM moves to TRACK on its first edge.
    - When match_cnt reaches STABLE_CNT -> LOCK. On entry: note_code = cand, note_valid = 1. note_strobe pulses if note_valid was 0 or note_code differed.
  - LOCK:
    - Edge with class == note_code: stay.
    - Edge with any other class -> TRACK, with cand/match_cnt set as above. note_valid and note_code hold the old note. This rides through glitch periods at note boundaries.
  - Timeout from any state except IDLE -> IDLE: note_valid = 0, note_code = 7, match_cnt = 0, no strobe.
- **Latency:** note_valid / note_strobe rise exactly 4 sys_clk edges after the beep_in rising edge that completes the STABLE_CNT-th match (2 synchroniser + 1 edge + 1 output register).
- **Reset values** (sys_rst sampled high, takes effect mid-operation as well):
  - State IDLE, note_code = 7, note_valid = 0, note_strobe = 0, period_out = 0.
  - All counters 0.
- **STABLE_CNT = 1:** a single matching period locks the note.

Optional Feature:
- **BEEP_DEC_DUTY_EN defined:**
  - An additional 18-bit low-time counter runs: cleared on the falling edge of synced beep_in, counts while low, captured on the rising edge.
  - A period classifies as note k only if it also satisfies |low - ((NOTE_k>>1)+1)| <= TOL. Otherwise the period is class 7.
- **Undefined:** no low-time logic; classification uses the period only.

Test Plan:
Bench overrides for all scenarios: DO..XI = 99, 89, 79, 74, 66, 59, 52; TOL = 3; STABLE_CNT = 3; TIMEOUT = 500.
- Reset, then square wave with period 100 cycles (low 50, high 50) -> note_valid rises 4 clocks after the 4th rising edge; note_code = 0; one note_strobe pulse; period_out = 99.
- Locked on DO, switch to period 80 -> note_valid stays 1 with code 0 until the 3rd period-80 edge +4 clocks; then code = 2 with one strobe.
- Locked on RE (period 90), insert one 37-cycle period -> no change to note_code/note_valid and no strobe; relock to code 1 without a strobe.
- Hold beep_in low after lock -> note_valid falls and note_code = 7 exactly at timeout (500 cycles after the last edge counter clear); no strobe.
- Periods of 104 (value 103, outside TOL) -> note_valid never asserts. Assert sys_rst for 1 cycle mid-lock -> all outputs at reset values on the next cycle.
- With BEEP_DEC_DUTY_EN, period 100 with low time 10 -> class 7, never locks. Without the macro -> locks to code 0.
